// File: rtl/main.sv
// main: 8-bit LIFO stack with one-cycle ops; ADD/SUB present only when MAIN_ARITH_EN is defined
module main #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic [2:0] op,
  input  logic       apply,
  output logic [7:0] tail,
  output logic       empty,
  output logic       valid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_SWAP = 3'b011, OP_POP = 3'b100;
  localparam logic [2:0] OP_PUSH = 3'b101, OP_DUP = 3'b110, OP_CLEAR = 3'b111;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW:0] depth_q, depth_d;
  logic [7:0] tail_q, tail_d;
  logic empty_q, empty_d, valid_q, valid_d;
  logic [AW-1:0] top_idx, sec_idx, push_idx, new_top_idx;
  logic [7:0] top, sec;
  assign top_idx = AW'(depth_q - ONE);
  assign sec_idx = AW'(depth_q - TWO);
  assign push_idx = AW'(depth_q);
  assign top = mem_q[top_idx];
  assign sec = mem_q[sec_idx];
  always_comb begin
    mem_d = mem_q;
    depth_d = depth_q;
    valid_d = valid_q;
    if (apply) begin
      valid_d = 1'b1;
      case (op)
`ifdef MAIN_ARITH_EN
        OP_ADD, OP_SUB: begin
          if (depth_q < TWO) valid_d = 1'b0;
          else begin
            mem_d[sec_idx] = (op == OP_ADD) ? sec + top : sec - top;
            depth_d = depth_q - ONE;
          end
        end
`else
        OP_ADD, OP_SUB: valid_d = 1'b0;
`endif
        OP_SWAP: begin
          if (depth_q < TWO) valid_d = 1'b0;
          else begin
            mem_d[top_idx] = sec;
            mem_d[sec_idx] = top;
          end
        end
        OP_POP: begin
          if (depth_q == '0) valid_d = 1'b0;
          else depth_d = depth_q - ONE;
        end
        OP_PUSH, OP_DUP: begin
          if (depth_q == FULL || (op == OP_DUP && depth_q == '0)) valid_d = 1'b0;
          else begin
            mem_d[push_idx] = (op == OP_PUSH) ? in : top;
            depth_d = depth_q + ONE;
          end
        end
        OP_CLEAR: depth_d = '0;
        default: ;
      endcase
    end
    new_top_idx = AW'(depth_d - ONE);
    tail_d = (depth_d == '0) ? 8'h00 : mem_d[new_top_idx];
    empty_d = (depth_d == '0);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      depth_q <= '0;
      tail_q <= 8'h00;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      tail_q <= tail_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      mem_q <= mem_d;
    end
  end
  assign tail = tail_q;
  assign empty = empty_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_main.sv
// tb_main: directed self-checking bench for the main stack
module tb_main;
  localparam int DEPTH = 8;
  localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010, SWAP = 3'b011;
  localparam logic [2:0] POP = 3'b100, PUSH = 3'b101, DUP = 3'b110, CLEAR = 3'b111;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in = 8'h00;
  logic [2:0] op = NOP;
  logic apply = 1'b0;
  logic [7:0] tail;
  logic empty, valid;
  int total = 0;
  int bad = 0;
  main #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .in(in), .op(op), .apply(apply), .tail(tail), .empty(empty), .valid(valid));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic a);
    op = o;
    in = d;
    apply = a;
    @(posedge clk);
    #1;
  endtask
  task automatic expect3(input string tag, input logic [7:0] t, input logic e, input logic v);
    check({tag, ".tail"}, tail, t);
    check({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
  endtask
  initial begin
    step(PUSH, 8'h77, 1'b1);
    expect3("reset", 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    step(PUSH, 8'h02, 1'b1);
    step(PUSH, 8'h04, 1'b1);
    step(PUSH, 8'h01, 1'b1);
    expect3("push3", 8'h01, 1'b0, 1'b1);
    step(SWAP, 8'h00, 1'b1);
    expect3("swap", 8'h04, 1'b0, 1'b1);
    step(POP, 8'h00, 1'b1);
    expect3("pop", 8'h01, 1'b0, 1'b1);
    step(PUSH, 8'h06, 1'b1);
    step(PUSH, 8'h25, 1'b1);
    expect3("push25", 8'h25, 1'b0, 1'b1);
    step(POP, 8'h00, 1'b1);
    expect3("pop6", 8'h06, 1'b0, 1'b1);
    step(DUP, 8'h00, 1'b1);
    expect3("dup", 8'h06, 1'b0, 1'b1);
    step(CLEAR, 8'h00, 1'b1);
    expect3("clear", 8'h00, 1'b1, 1'b1);
    step(SWAP, 8'h00, 1'b1);
    expect3("swap_empty", 8'h00, 1'b1, 1'b0);
    step(NOP, 8'h00, 1'b1);
    expect3("nop", 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(PUSH, 8'(i * 3), 1'b1);
      check("fill", tail, 8'(i * 3));
    end
    step(PUSH, 8'hAA, 1'b1);
    expect3("overflow", 8'(DEPTH * 3), 1'b0, 1'b0);
    step(DUP, 8'h00, 1'b1);
    expect3("dup_full", 8'(DEPTH * 3), 1'b0, 1'b0);
    for (int i = DEPTH - 1; i >= 1; i--) begin
      step(POP, 8'h00, 1'b1);
      check("drain", tail, 8'(i * 3));
    end
    step(POP, 8'h00, 1'b1);
    expect3("last_pop", 8'h00, 1'b1, 1'b1);
    step(POP, 8'h00, 1'b1);
    expect3("underflow", 8'h00, 1'b1, 1'b0);
    step(PUSH, 8'h99, 1'b0);
    expect3("idle_hold", 8'h00, 1'b1, 1'b0);
    step(PUSH, 8'hF0, 1'b1);
    step(PUSH, 8'h20, 1'b1);
    step(ADD, 8'h00, 1'b1);
`ifdef MAIN_ARITH_EN
    expect3("add", 8'h10, 1'b0, 1'b1);
    step(PUSH, 8'h30, 1'b1);
    step(SUB, 8'h00, 1'b1);
    expect3("sub", 8'hE0, 1'b0, 1'b1);
    step(POP, 8'h00, 1'b1);
    expect3("arith_depth", 8'h00, 1'b1, 1'b1);
    step(PUSH, 8'h05, 1'b1);
    step(SUB, 8'h00, 1'b1);
    expect3("sub_short", 8'h05, 1'b0, 1'b0);
`else
    expect3("add_off", 8'h20, 1'b0, 1'b0);
    step(SUB, 8'h00, 1'b1);
    expect3("sub_off", 8'h20, 1'b0, 1'b0);
`endif
    rst = 1'b0;
    step(PUSH, 8'h55, 1'b1);
    expect3("rst_mid", 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    step(PUSH, 8'h66, 1'b0);
    step(POP, 8'h00, 1'b0);
    expect3("rst_hold", 8'h00, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
